// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ROM between NUM_REQ requesters.
// Optional address range checking is enabled with the ROM_ARB_RANGE_CHECK_EN macro.
module rom_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ROM_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic                          busy
`ifdef ROM_ARB_RANGE_CHECK_EN
  ,
  output logic                          resp_err
`endif
);

  localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_DEPTH = 32'd1 << ADDR_WIDTH;

  // Reject parameter sets the arbiter is not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ROM_DEPTH == 0 || ROM_DEPTH > MAX_DEPTH) begin : g_param_check
    $error("rom_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       sel;
  logic                found;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin : pick_blk
    int unsigned   idx;
    logic [GW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_addr = req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];

  // Accept strobe only exists while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && found) req_ready[sel] = 1'b1;
  end

`ifdef ROM_ARB_RANGE_CHECK_EN
  logic in_range;
  logic err_pend;
  assign in_range = ({1'b0, sel_addr} < (ADDR_WIDTH+1)'(ROM_DEPTH));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
`ifdef ROM_ARB_RANGE_CHECK_EN
      resp_err   <= 1'b0;
      err_pend   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
`ifdef ROM_ARB_RANGE_CHECK_EN
            if (in_range) rom_addr <= sel_addr;
            err_pend <= !in_range;
`else
            rom_addr <= sel_addr;
`endif
            grant <= sel;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
`ifdef ROM_ARB_RANGE_CHECK_EN
          resp_data <= err_pend ? '0 : rom_data;
          resp_err  <= err_pend;
`else
          resp_data <= rom_data;
`endif
          resp_valid <= NUM_REQ'(1) << grant;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= '0;
`ifdef ROM_ARB_RANGE_CHECK_EN
          resp_err   <= 1'b0;
`endif
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter: cycle model plus response scoreboard.
module tb_rom_rr_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef ROM_ARB_RANGE_CHECK_EN
  localparam int DEPTH = 128;
`else
  localparam int DEPTH = 256;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_data;
  logic             busy;
`ifdef ROM_ARB_RANGE_CHECK_EN
  logic             resp_err;
`endif

  rom_rr_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .ROM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
`ifdef ROM_ARB_RANGE_CHECK_EN
    , .resp_err(resp_err)
`endif
  );

  always #5 clk = ~clk;
  assign rom_data = rom_addr ^ 8'hA5;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb_q[$];
  rsp_t obs_q[$];
  int   mstate, mlast, mgrant;
  logic [7:0] mrom;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (mlast + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] addr_of(input int i);
    logic [NR*AW-1:0] a;
    a = req_addr;
    return a[i*AW +: AW];
  endfunction

  // One clock: compare outputs mid-cycle, advance the model at the edge.
  task automatic tick();
    int p;
    logic [NR-1:0] er;
    logic [NR-1:0] erv;
    rsp_t e, o;
    #1;
    if (rst) begin
      mstate = 0; mlast = NR - 1; mrom = 8'h00; sb_q.delete();
    end
    p   = pick();
    er  = (mstate == 0 && !rst && p >= 0) ? NR'(1) << p : '0;
    erv = (mstate == 2) ? NR'(1) << mgrant : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(erv));
    chk("busy", 32'(busy), 32'(mstate != 0));
    chk("rom_addr", 32'(rom_addr), 32'(mrom));
    if (resp_valid != '0) begin
      o.idx = 2'd0;
      for (int i = 0; i < NR; i++) if (resp_valid[i]) o.idx = 2'(i);
      o.data = resp_data;
`ifdef ROM_ARB_RANGE_CHECK_EN
      o.err = resp_err;
`else
      o.err = 1'b0;
`endif
      obs_q.push_back(o);
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_err", 32'(o.err), 32'(e.err));
      end
    end
    @(posedge clk);
    if (!rst) begin
      case (mstate)
        0: if (p >= 0) begin
          e.idx  = 2'(p);
          e.err  = (int'(addr_of(p)) >= DEPTH);
          e.data = e.err ? 8'h00 : (addr_of(p) ^ 8'hA5);
          if (!e.err) mrom = addr_of(p);
          sb_q.push_back(e);
          mgrant = p;
          mstate = 1;
        end
        1: mstate = 2;
        default: begin
          mstate = 0;
          mlast  = mgrant;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic chk_obs(input string tag, input int n, input rsp_t r);
    rsp_t got;
    got = (obs_q.size() > n) ? obs_q[n] : '1;
    chk(tag, 32'(got), 32'(r));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0;
    mstate = 0; mlast = NR - 1; mgrant = 0; mrom = 8'h00;
    @(negedge clk);
    tick();
    chk("reset_resp_data", 32'(resp_data), 32'h0);
    rst = 1'b0;
    tick(); tick();

    // Single request from requester 2.
    set_addr(2, 8'h10); req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("single_count", 32'(obs_q.size()), 32'd1);
    chk_obs("single_resp", 0, '{2'd2, 8'hB5, 1'b0});

    // Round robin after a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0; obs_q.delete();
    for (int i = 0; i < NR; i++) set_addr(i, 8'(i));
    req_valid = 4'b1111;
    repeat (15) tick();
    req_valid = '0;
    tick(); tick();
    chk("rr_count", 32'(obs_q.size()), 32'd5);
    chk_obs("rr_0", 0, '{2'd0, 8'hA5, 1'b0});
    chk_obs("rr_1", 1, '{2'd1, 8'hA4, 1'b0});
    chk_obs("rr_2", 2, '{2'd2, 8'hA7, 1'b0});
    chk_obs("rr_3", 3, '{2'd3, 8'hA6, 1'b0});
    chk_obs("rr_4", 4, '{2'd0, 8'hA5, 1'b0});

    // Wrap priority: serve requester 3, then 0 and 3 together.
    set_addr(3, 8'h33); req_valid = 4'b1000;
    tick(); req_valid = '0; tick(); tick(); tick();
    obs_q.delete();
    set_addr(0, 8'h20); req_valid = 4'b1001;
    tick();
    req_valid = 4'b1000;
    tick(); tick(); tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("wrap_count", 32'(obs_q.size()), 32'd2);
    chk_obs("wrap_0", 0, '{2'd0, 8'h85, 1'b0});
    chk_obs("wrap_1", 1, '{2'd3, 8'h96, 1'b0});

    // Reset during READ aborts the transaction.
    obs_q.delete();
    set_addr(1, 8'h44); req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    chk("midrst_rom_addr", 32'(rom_addr), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("midrst_no_resp", 32'(obs_q.size()), 32'd0);
    set_addr(0, 8'h01); set_addr(3, 8'h02); req_valid = 4'b1001;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk_obs("midrst_next", 0, '{2'd0, 8'hA4, 1'b0});

    // Request raised during READ and dropped before IDLE is ignored.
    obs_q.delete();
    set_addr(0, 8'h5A); set_addr(1, 8'h11); req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("cancel_count", 32'(obs_q.size()), 32'd1);
    chk_obs("cancel_resp", 0, '{2'd0, 8'hFF, 1'b0});

`ifdef ROM_ARB_RANGE_CHECK_EN
    // Out-of-range and last in-range address.
    obs_q.delete();
    set_addr(2, 8'h80); req_valid = 4'b0100;
    tick(); req_valid = '0; tick(); tick(); tick();
    chk("range_rom_addr", 32'(rom_addr), 32'h5A);
    set_addr(2, 8'h7F); req_valid = 4'b0100;
    tick(); req_valid = '0; tick(); tick(); tick();
    chk_obs("range_bad", 0, '{2'd2, 8'h00, 1'b1});
    chk_obs("range_ok", 1, '{2'd2, 8'hDA, 1'b0});
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares one combinational read-only memory (addr in, data_out out, no clock) between NUM_REQ requesters.
- Each requester issues single-word reads with a valid/ready handshake. A round-robin arbiter picks one requester, drives the ROM address from a register, captures the ROM word, and returns it with a one-cycle per-requester response strobe.
- Sits between the ROM instance and the blocks that consume table data.

Parameters:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 8, ROM address width.
- NUM_REQ, 4, number of requesters (2..8).
- ROM_DEPTH, 256, number of valid ROM words (<= 2**ADDR_WIDTH). Used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_data  out  DATA_WIDTH  returned word; valid while any resp_valid bit is high.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_data  in  DATA_WIDTH  ROM data_out, combinational from rom_addr.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; rom_addr=0; resp_data=0; resp_valid=0; busy=0.
  - req_ready=0 while rst is high.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - If any req_valid is high, sel = first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready is driven combinationally: one-hot of sel in IDLE, 0 in every other state and when no request is pending.
  - On the edge where req_valid[sel]&req_ready[sel]=1: rom_addr<=req_addr[sel], grant<=sel, state<=READ.
- READ:
  - rom_data is valid for rom_addr.
  - At the next edge: resp_data<=rom_data, resp_valid<=onehot(grant), state<=RESP.
- RESP:
  - resp_valid is high for exactly this one cycle.
  - At the next edge: resp_valid<=0, last_grant<=grant, state<=IDLE.
- Latency and throughput:
  - Acceptance edge E0 -> resp_valid high between edges E0+1 and E0+2.
  - Throughput is one access per 3 cycles; there is no back-to-back overlap.
- resp_data holds its last value after RESP until the next capture.
- rom_addr holds after acceptance until the next acceptance.
- Requester rules:
  - A requester must hold req_valid and req_addr stable until it sees req_ready.
  - Deasserting req_valid before acceptance cancels the request with no side effect.
  - req_valid seen in READ or RESP is ignored until IDLE. There is no queueing.
- Simultaneous requests: exactly one is granted per round. A continuously asserted requester waits at most NUM_REQ-1 rounds.
- Reset mid-operation: the transaction is aborted, no resp_valid is emitted, and the arbiter returns to reset state.
- Addresses wrap naturally at ADDR_WIDTH bits; no other range checking is done unless the optional feature is enabled.

Optional Feature:
- Macro: ROM_ARB_RANGE_CHECK_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0).
  - On acceptance with req_addr[sel] >= ROM_DEPTH: rom_addr is left unchanged; in READ, resp_data<=0 and resp_err<=1; resp_err is high together with resp_valid for that single cycle.
  - In-range accesses drive resp_err=0.
  - Latency is unchanged.
- Not defined: no resp_err port, no comparison; all addresses go to the ROM.

Test Plan:
- ROM model for all scenarios: rom_data = rom_addr ^ 8'hA5.
- Single request: after reset, req_valid[2]=1, addr 8'h10 -> req_ready=4'b0100 for one cycle; resp_valid=4'b0100 two edges later with resp_data=8'hB5; busy high for 2 cycles.
- Round robin: all four req_valid held high with addrs 0,1,2,3 -> grant order 0,1,2,3,0 with resp_data A5,A4,A7,A6; each resp_valid one cycle; 3 cycles per grant.
- Wrap priority: last_grant=3, req_valid=4'b1001 -> requester 0 is granted first, then 3.
- Reset mid-op: rst pulsed high during READ -> resp_valid stays 0; rom_addr=0, busy=0, req_ready=0; requester 0 wins the next round.
- Cancel and ignore: req_valid[1] raised during READ then dropped before IDLE -> no grant to 1 and no resp_valid[1].
- ROM_ARB_RANGE_CHECK_EN with ROM_DEPTH=128: addr 8'h80 -> resp_err=1, resp_data=0, rom_addr unchanged. Addr 8'h7F -> resp_err=0, resp_data=8'hDA.
